// File: rtl/data_array_fill_ctrl.sv
// data_array_fill_ctrl: gathers refill words into bank-wide beats and writes a
// cache line into the data array one beat at a time.
module data_array_fill_ctrl #(
   parameter int SET_BITS_WIDTH = 4,
   parameter int WAY_BITS_WIDTH = 2,
   parameter int WORD_WIDTH     = 20,
   parameter int WORDS_PER_BEAT = 4,
   parameter int BEATS_PER_LINE = 4
) (
   input  logic                                 clk,
   input  logic                                 arst_n,
   input  logic                                 i_halt_all,
   input  logic                                 i_flush,
   input  logic                                 i_fill_req_valid,
   input  logic [SET_BITS_WIDTH-1:0]            i_fill_set,
   input  logic [WAY_BITS_WIDTH-1:0]            i_fill_way,
   output logic                                 o_fill_req_ready,
   input  logic [WORD_WIDTH-1:0]                i_mem_data,
   input  logic                                 i_mem_valid,
   output logic                                 o_mem_ready,
   output logic [SET_BITS_WIDTH-1:0]            o_w_set_bits,
   output logic [WAY_BITS_WIDTH-1:0]            o_w_way_index,
   output logic [1:0]                           o_w_block_offset_bits,
   output logic [WORD_WIDTH*WORDS_PER_BEAT-1:0] o_w_data,
   output logic                                 o_w_valid,
   output logic                                 o_stop_write_clk,
   output logic                                 o_busy,
   output logic                                 o_fill_done
);
   localparam int WCW = $clog2(WORDS_PER_BEAT);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t                              r_state;
   logic [WCW-1:0]                      r_word_cnt;
   logic [1:0]                          r_beat_cnt;
   logic [SET_BITS_WIDTH-1:0]           r_set;
   logic [WAY_BITS_WIDTH-1:0]           r_way;
   logic [WORD_WIDTH*WORDS_PER_BEAT-1:0] r_data;
   logic                                r_stop;

   // Handshakes close during halt and flush so no word or request slips in
   assign o_fill_req_ready      = (r_state == IDLE) & ~i_halt_all & ~i_flush;
   assign o_mem_ready           = (r_state == COLLECT) & ~i_halt_all & ~i_flush;
   assign o_w_valid             = (r_state == WRITE) & ~i_flush;
   assign o_fill_done           = (r_state == DONE) & ~i_flush;
   assign o_busy                = r_state != IDLE;
   assign o_stop_write_clk      = r_stop;
   assign o_w_set_bits          = r_set;
   assign o_w_way_index         = r_way;
   assign o_w_block_offset_bits = r_beat_cnt;
   assign o_w_data              = r_data;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state    <= IDLE;
         r_word_cnt <= '0;
         r_beat_cnt <= '0;
         r_set      <= '0;
         r_way      <= '0;
         r_data     <= '0;
         r_stop     <= 1'b1;
      end else if (i_flush) begin
         r_state    <= IDLE;
         r_word_cnt <= '0;
         r_beat_cnt <= '0;
         r_stop     <= 1'b1;
      end else if (!i_halt_all) begin
         case (r_state)
            IDLE: if (i_fill_req_valid) begin
               r_set      <= i_fill_set;
               r_way      <= i_fill_way;
               r_word_cnt <= '0;
               r_beat_cnt <= '0;
               r_state    <= COLLECT;
            end
            COLLECT: if (i_mem_valid) begin
               r_data[r_word_cnt*WORD_WIDTH +: WORD_WIDTH] <= i_mem_data;
               if (r_word_cnt == WCW'(WORDS_PER_BEAT-1)) begin
                  r_word_cnt <= '0;
                  r_state    <= WRITE;
                  r_stop     <= 1'b0;
               end else begin
                  r_word_cnt <= r_word_cnt + 1'b1;
               end
            end
            WRITE: begin
               r_stop <= 1'b1;
               if (r_beat_cnt == 2'(BEATS_PER_LINE-1)) begin
                  r_state <= DONE;
               end else begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  r_state    <= COLLECT;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_array_fill_ctrl.sv
// tb_data_array_fill_ctrl: scoreboard bench; expected beats are derived from the
// line-to-bank mapping (word w -> bank w%4, beat w/4) when a fill is issued.
module tb_data_array_fill_ctrl;
   localparam int WW = 20;

   typedef struct {
      logic [3:0]  set;
      logic [1:0]  way;
      logic [1:0]  off;
      logic [79:0] data;
      int          rel;
   } wr_t;

   logic          clk = 0;
   logic          arst_n = 0;
   logic          i_halt_all = 0;
   logic          i_flush = 0;
   logic          i_fill_req_valid = 0;
   logic [3:0]    i_fill_set = 0;
   logic [1:0]    i_fill_way = 0;
   logic          o_fill_req_ready;
   logic [WW-1:0] i_mem_data = 0;
   logic          i_mem_valid = 0;
   logic          o_mem_ready;
   logic [3:0]    o_w_set_bits;
   logic [1:0]    o_w_way_index;
   logic [1:0]    o_w_block_offset_bits;
   logic [79:0]   o_w_data;
   logic          o_w_valid;
   logic          o_stop_write_clk;
   logic          o_busy;
   logic          o_fill_done;

   data_array_fill_ctrl dut (
      .clk(clk), .arst_n(arst_n), .i_halt_all(i_halt_all), .i_flush(i_flush),
      .i_fill_req_valid(i_fill_req_valid), .i_fill_set(i_fill_set), .i_fill_way(i_fill_way),
      .o_fill_req_ready(o_fill_req_ready), .i_mem_data(i_mem_data), .i_mem_valid(i_mem_valid),
      .o_mem_ready(o_mem_ready), .o_w_set_bits(o_w_set_bits), .o_w_way_index(o_w_way_index),
      .o_w_block_offset_bits(o_w_block_offset_bits), .o_w_data(o_w_data), .o_w_valid(o_w_valid),
      .o_stop_write_clk(o_stop_write_clk), .o_busy(o_busy), .o_fill_done(o_fill_done)
   );

   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            gap_mode = 0;
   bit            halt_en = 0;
   bit            halt_force = 0;
   wr_t           exp_q[$];
   int            done_q[$];
   logic [WW-1:0] mem_q[$];

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc - acc_cyc);
      end
   endtask

   // Halt driver: forced windows for directed tests, random stalls otherwise
   initial forever begin
      @(posedge clk);
      #2;
      i_halt_all = halt_force | (halt_en & ($urandom_range(0, 3) == 0));
   end

   // Memory source: mode 0 back-to-back, 1 one gap before every word, 2 random gaps
   initial begin
      bit acc, rdy, tog;
      tog = 0;
      forever begin
         @(negedge clk);
         acc = i_mem_valid & o_mem_ready;
         rdy = o_mem_ready;
         @(posedge clk);
         #1;
         if (acc && mem_q.size() > 0) mem_q.delete(0);
         if (mem_q.size() == 0) tog = 0;
         else if (rdy) tog = ~tog;
         i_mem_data  = mem_q.size() > 0 ? mem_q[0] : '0;
         i_mem_valid = mem_q.size() > 0 &&
                       (gap_mode == 0 || (gap_mode == 1 && tog) ||
                        (gap_mode == 2 && $urandom_range(0, 2) != 0));
      end
   end

   // Monitor: every write cycle is compared to the head; the head retires on the unhalted cycle
   initial forever begin
      @(negedge clk);
      if (o_w_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 1'b1, 1'b0);
         end else begin
            chk("w_set", o_w_set_bits, exp_q[0].set);
            chk("w_way", o_w_way_index, exp_q[0].way);
            chk("w_off", o_w_block_offset_bits, exp_q[0].off);
            chk("w_data", o_w_data, exp_q[0].data);
            chk("w_stop_clk", o_stop_write_clk, 1'b0);
            if (!i_halt_all) begin
               if (exp_q[0].rel >= 0) chk("w_cycle", cyc - acc_cyc, exp_q[0].rel);
               exp_q.delete(0);
            end
         end
      end
      if (o_fill_done && !i_halt_all) begin
         if (done_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
         else begin
            if (done_q[0] >= 0) chk("done_cycle", cyc - acc_cyc, done_q[0]);
            done_q.delete(0);
         end
      end
   end

   task automatic fill(input logic [3:0] s, input logic [1:0] w, input logic [WW-1:0] words[16],
                       input int wc[4], input int dc);
      logic [79:0] beat[4];
      bit ok;
      for (int b = 0; b < 4; b++) beat[b] = '0;
      for (int k = 0; k < 16; k++) beat[k / 4][(k % 4) * WW +: WW] = words[k];
      for (int b = 0; b < 4; b++) exp_q.push_back('{s, w, 2'(b), beat[b], wc[b]});
      done_q.push_back(dc);
      for (int k = 0; k < 16; k++) mem_q.push_back(words[k]);
      i_fill_req_valid = 1;
      i_fill_set = s;
      i_fill_way = w;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (o_fill_req_ready) begin
            ok = 1;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      chk("req_accept", ok, 1'b1);
      // Keep a junk request asserted mid-fill; it must not be taken
      i_fill_set = ~s;
      i_fill_way = ~w;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         seen = o_fill_done;
      end
      chk("done_seen", seen, 1'b1);
      @(posedge clk);
      #1;
      i_fill_req_valid = 0;
   endtask

   task automatic to_cycle(input int k);
      for (int i = 0; i < 200 && cyc != acc_cyc + k; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_w_valid"}, o_w_valid, 1'b0);
      chk({tag, "_done"}, o_fill_done, 1'b0);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_stop_clk"}, o_stop_write_clk, 1'b1);
      chk({tag, "_mem_ready"}, o_mem_ready, 1'b0);
      chk({tag, "_req_ready"}, o_fill_req_ready, 1'b1);
   endtask

   initial begin
      logic [WW-1:0] words[16];
      int nt[4];
      nt = '{-1, -1, -1, -1};
      #12;
      chk_reset_outs("rst");
      @(negedge clk);
      arst_n = 1;
      idle(2);

      // Back-to-back line: writes at 5/10/15/20, done at 21
      for (int k = 0; k < 16; k++) words[k] = WW'(k);
      fill(4'd5, 2'd2, words, '{5, 10, 15, 20}, 21);
      wait_done();
      idle(3);

      // A gap before every word: each beat takes nine cycles
      gap_mode = 1;
      fill(4'd5, 2'd2, words, '{9, 18, 27, 36}, 37);
      wait_done();
      gap_mode = 0;
      idle(3);

      // Three-cycle halt on the beat-1 write stretches it to four cycles
      for (int k = 0; k < 16; k++) words[k] = WW'($urandom);
      fill(4'd3, 2'd1, words, '{5, 13, 18, 23}, 24);
      to_cycle(10);
      halt_force = 1;
      idle(3);
      halt_force = 0;
      wait_done();
      idle(3);

      // Flush during beat-2 collection abandons the rest of the line
      fill(4'd12, 2'd3, words, '{5, 10, -1, -1}, -1);
      to_cycle(12);
      i_flush = 1;
      i_fill_req_valid = 0;
      exp_q.delete();
      done_q.delete();
      idle(1);
      i_flush = 0;
      @(negedge clk);
      chk("flush_busy", o_busy, 1'b0);
      chk("flush_req_ready", o_fill_req_ready, 1'b1);
      mem_q.delete();
      idle(6);
      for (int k = 0; k < 16; k++) words[k] = WW'($urandom);
      fill(4'd9, 2'd1, words, '{5, 10, 15, 20}, 21);
      wait_done();
      idle(3);

      // Asynchronous reset mid beat 3
      fill(4'd7, 2'd0, words, '{5, 10, 15, -1}, -1);
      to_cycle(17);
      #3;
      arst_n = 0;
      i_fill_req_valid = 0;
      #1;
      chk_reset_outs("midrst");
      exp_q.delete();
      done_q.delete();
      @(negedge clk);
      arst_n = 1;
      idle(10);
      @(negedge clk);
      chk("post_rst_busy", o_busy, 1'b0);
      mem_q.delete();
      idle(2);

      // Random lines with random memory gaps and random halts
      gap_mode = 2;
      halt_en = 1;
      for (int f = 0; f < 24; f++) begin
         for (int k = 0; k < 16; k++) words[k] = WW'($urandom);
         fill(4'($urandom), 2'($urandom), words, nt, -1);
         wait_done();
         idle($urandom_range(0, 3));
      end
      halt_en = 0;
      idle(5);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
